// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C key-code scheduler.
package i2c_pkg;

   // Transaction sequencer states. Retry handling is folded into the WAIT states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_WAIT,
      ST_DATA,
      ST_DATA_WAIT,
      ST_GAP
   } state_t;

   // R/W bit appended to the 7-bit address; this block only ever writes.
   localparam logic       RW_WRITE           = 1'b0;
   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h27;

   // First byte on the wire: target address followed by the write bit.
   function automatic logic [7:0] addr_byte(input logic [6:0] addr);
      return {addr, RW_WRITE};
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Small FIFO of key codes between the arbiter and the I2C sequencer.
// The head entry is readable combinationally so the sequencer can pop it
// into its hold register in the same cycle it leaves IDLE.
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_do_push;
   logic w_do_pop;

   // Guard against overflow/underflow even though the arbiter never pushes when full.
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   assign full    = (r_count == LP_DEPTH);
   assign empty   = (r_count == CW'(0));
   assign rd_data = r_mem[r_rd_ptr];

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/i2c_key_scheduler.sv
// Arbitrates key codes from two requesters into a FIFO and sends each one
// to a fixed I2C target as an address byte plus a data byte, with bounded
// retries on NACK and a forced idle gap between transactions.
module i2c_key_scheduler
   import i2c_pkg::*;
#(
   parameter int         DEPTH      = 4,
   parameter int         MAX_RETRY  = 3,
   parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
   parameter int         GAP_CYCLES = 8
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic [7:0] data_a,
   input  logic       req_b,
   input  logic [7:0] data_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_first,
   output logic       m_last,
   input  logic       m_ready,
   input  logic       m_done,
   input  logic       m_nack,
   output logic       busy,
   output logic       err,
   output logic [7:0] drop_cnt
);

   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] LP_MAX_RETRY = RETRY_W'(MAX_RETRY);
   localparam logic [7:0]         LP_GAP_LAST  = 8'(GAP_CYCLES - 1);

   state_t               r_state;
   logic [7:0]           r_hold;
   logic [RETRY_W-1:0]   r_retry;
   logic [7:0]           r_gap;
   logic [7:0]           r_drop_cnt;
   logic                 r_err;
   logic                 r_m_valid;
   logic [7:0]           r_m_data;
   logic                 r_m_first;
   logic                 r_m_last;
   logic                 r_last_b;

   logic                 w_gnt_a;
   logic                 w_gnt_b;
   logic [7:0]           w_gnt_data;
   logic                 w_push;
   logic                 w_pop;
   logic [7:0]           w_fifo_rd_data;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;

   key_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_key_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push),
      .wr_data (w_gnt_data),
      .pop     (w_pop),
      .rd_data (w_fifo_rd_data),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty)
   );

   // Round-robin grant: on a tie the requester not granted last time wins; nothing while full.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (!rst && !w_fifo_full) begin
         if (req_a && req_b) begin
            if (r_last_b) w_gnt_a = 1'b1;
            else          w_gnt_b = 1'b1;
         end else if (req_a) begin
            w_gnt_a = 1'b1;
         end else if (req_b) begin
            w_gnt_b = 1'b1;
         end
      end
   end

   // A zero code is acknowledged to the requester but never queued.
   assign w_gnt_data = w_gnt_a ? data_a : data_b;
   assign w_push     = (w_gnt_a || w_gnt_b) && (w_gnt_data != 8'h00);
   assign w_pop      = (r_state == ST_IDLE) && !w_fifo_empty;

   // Remember who was granted last so the other side wins the next tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_b <= 1'b1;
      end else if (w_gnt_a) begin
         r_last_b <= 1'b0;
      end else if (w_gnt_b) begin
         r_last_b <= 1'b1;
      end
   end

   // Transaction sequencer with registered byte-offer outputs, retry and drop accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_hold     <= '0;
         r_retry    <= '0;
         r_gap      <= '0;
         r_drop_cnt <= '0;
         r_err      <= 1'b0;
         r_m_valid  <= 1'b0;
         r_m_data   <= '0;
         r_m_first  <= 1'b0;
         r_m_last   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_fifo_empty) begin
                  r_hold    <= w_fifo_rd_data;
                  r_state   <= ST_ADDR;
                  r_m_valid <= 1'b1;
                  r_m_data  <= addr_byte(SLAVE_ADDR);
                  r_m_first <= 1'b1;
                  r_m_last  <= 1'b0;
               end
            end
            ST_ADDR: begin
               if (m_ready) begin
                  r_state   <= ST_ADDR_WAIT;
                  r_m_valid <= 1'b0;
                  r_m_first <= 1'b0;
               end
            end
            ST_DATA: begin
               if (m_ready) begin
                  r_state   <= ST_DATA_WAIT;
                  r_m_valid <= 1'b0;
                  r_m_last  <= 1'b0;
               end
            end
            ST_ADDR_WAIT, ST_DATA_WAIT: begin
               if (m_done) begin
                  if (!m_nack) begin
                     if (r_state == ST_ADDR_WAIT) begin
                        r_state   <= ST_DATA;
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_hold;
                        r_m_first <= 1'b0;
                        r_m_last  <= 1'b1;
                     end else begin
                        r_state <= ST_GAP;
                        r_retry <= '0;
                        r_gap   <= '0;
                     end
                  end else if (r_retry < LP_MAX_RETRY) begin
                     // NACK on either byte restarts the whole transaction with the same code.
                     r_retry   <= r_retry + RETRY_W'(1);
                     r_state   <= ST_ADDR;
                     r_m_valid <= 1'b1;
                     r_m_data  <= addr_byte(SLAVE_ADDR);
                     r_m_first <= 1'b1;
                     r_m_last  <= 1'b0;
                  end else begin
                     r_err   <= 1'b1;
                     r_retry <= '0;
                     r_gap   <= '0;
                     r_state <= ST_GAP;
                     if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
                  end
               end
            end
            ST_GAP: begin
               if (r_gap == LP_GAP_LAST) begin
                  r_gap   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap <= r_gap + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt_a    = w_gnt_a;
   assign gnt_b    = w_gnt_b;
   assign m_valid  = r_m_valid;
   assign m_data   = r_m_data;
   assign m_first  = r_m_first;
   assign m_last   = r_m_last;
   assign err      = r_err;
   assign drop_cnt = r_drop_cnt;
   assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_i2c_key_scheduler.sv
// Self-checking bench for i2c_key_scheduler: directed table, hand-written
// corner sequences, and a randomized run checked against a transaction model.
module tb_i2c_key_scheduler;

   localparam int         DEPTH     = 4;
   localparam int         MAX_RETRY = 3;
   localparam int         GAP       = 8;
   localparam int         DONE_LAT  = 4;
   localparam logic [7:0] ADDR_BYTE = 8'h4E;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic [7:0] data_a = '0, data_b = '0;
   logic       gnt_a, gnt_b;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_first, m_last;
   logic       m_ready = 1'b0, m_done = 1'b0, m_nack = 1'b0;
   logic       busy, err;
   logic [7:0] drop_cnt;

   always #5 clk = ~clk;

   i2c_key_scheduler #(
      .DEPTH      (DEPTH),
      .MAX_RETRY  (MAX_RETRY),
      .SLAVE_ADDR (7'h27),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_a    (req_a),
      .data_a   (data_a),
      .req_b    (req_b),
      .data_b   (data_b),
      .gnt_a    (gnt_a),
      .gnt_b    (gnt_b),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_first  (m_first),
      .m_last   (m_last),
      .m_ready  (m_ready),
      .m_done   (m_done),
      .m_nack   (m_nack),
      .busy     (busy),
      .err      (err),
      .drop_cnt (drop_cnt)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       first;
      logic       last;
   } beat_t;

   typedef struct packed {
      logic       ra;
      logic       rb;
      logic [7:0] da;
      logic [7:0] db;
      logic       ega;
      logic       egb;
      logic       ebusy;
      logic       emv;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Master-model controls and observations.
   bit         ready_en   = 1'b0;
   bit         ready_rand = 1'b0;
   int         nack_mode  = 0;
   bit         pend       = 1'b0;
   bit         pend_nack  = 1'b0;
   int         pend_cnt   = 0;
   bit         prev_valid = 1'b0;
   bit         prev_ready = 1'b0;
   beat_t      prev_beat;
   beat_t      log_q[$];
   bit         nack_q[$];
   logic [7:0] codes_q[$];
   int         err_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Byte master: accepts offers, pulses done DONE_LAT cycles later, chooses ACK/NACK.
   always @(negedge clk) begin
      bit n;
      m_done = 1'b0;
      m_nack = 1'b0;
      if (rst) begin
         pend       = 1'b0;
         pend_cnt   = 0;
         prev_valid = 1'b0;
         m_ready    = 1'b0;
         log_q.delete();
         nack_q.delete();
      end else begin
         if (prev_valid && !prev_ready && m_valid)
            chk("offer_hold", {m_data, m_first, m_last}, prev_beat);
         prev_valid = m_valid;
         prev_beat  = {m_data, m_first, m_last};
         m_ready    = ready_rand ? 1'($urandom_range(0, 1)) : ready_en;
         prev_ready = m_ready;
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               m_done = 1'b1;
               m_nack = pend_nack;
               pend   = 1'b0;
            end
         end else if (m_valid && m_ready) begin
            log_q.push_back({m_data, m_first, m_last});
            case (nack_mode)
               1:       n = m_first;
               2:       n = ($urandom_range(0, 3) == 0);
               default: n = 1'b0;
            endcase
            nack_q.push_back(n);
            pend_nack = n;
            pend      = 1'b1;
            pend_cnt  = DONE_LAT;
         end
      end
   end

   // Records accepted non-zero codes and err pulses.
   always @(negedge clk) begin
      if (rst) begin
         codes_q.delete();
         err_seen = 0;
      end else begin
         if (gnt_a && data_a != 8'h00) codes_q.push_back(data_a);
         if (gnt_b && data_b != 8'h00) codes_q.push_back(data_b);
         if (err) err_seen++;
      end
   end

   task automatic at_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_a = 1'b0;
      req_b = 1'b0;
      data_a = '0;
      data_b = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((busy || pend) && n < 3000) begin
         at_neg();
         n++;
      end
      chk({name, "_drain_timeout"}, (n < 3000), 1);
      repeat (2) at_neg();
   endtask

   // Transaction-level prediction: each code is sent as address then data; any NACK
   // restarts it, and after MAX_RETRY restarts a further NACK abandons it.
   task automatic model_check(input string tag);
      beat_t exp_q[$];
      int drops = 0;
      int ni = 0;
      int tries;
      bit fin;
      bit nk;
      int nlim;
      foreach (codes_q[i]) begin
         tries = 0;
         fin = 1'b0;
         while (!fin) begin
            exp_q.push_back({ADDR_BYTE, 1'b1, 1'b0});
            nk = (ni < nack_q.size()) ? nack_q[ni] : 1'b0;
            ni++;
            if (!nk) begin
               exp_q.push_back({codes_q[i], 1'b0, 1'b1});
               nk = (ni < nack_q.size()) ? nack_q[ni] : 1'b0;
               ni++;
               if (!nk) fin = 1'b1;
            end
            if (!fin) begin
               tries++;
               if (tries > MAX_RETRY) begin
                  drops++;
                  fin = 1'b1;
               end
            end
         end
      end
      chk({tag, "_len"}, log_q.size(), exp_q.size());
      nlim = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < nlim; i++)
         chk($sformatf("%s_beat%0d", tag, i), log_q[i], exp_q[i]);
      chk({tag, "_nacks_used"}, ni, nack_q.size());
      chk({tag, "_drop_cnt"}, drop_cnt, drops);
      chk({tag, "_err_pulses"}, err_seen, drops);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[10];
      logic [7:0] data_seq[$];
      logic [7:0] exp_seq[5];
      bit         found;
      bit         any_valid;
      bit         last_b;
      int         n_grants;

      // inputs {ra, rb, da, db}, expected {gnt_a, gnt_b, busy, m_valid}; master never ready
      tbl[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_seq = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11};

      // Reset then idle: everything quiet for 20 cycles.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         at_neg();
         chk($sformatf("idle_outputs_c%0d", i),
             {gnt_a, gnt_b, m_valid, m_first, m_last, m_data, err, busy, drop_cnt}, '0);
      end

      // Table: arbitration, zero discard, fill to full with a stalled master.
      ready_en = 1'b0;
      nack_mode = 0;
      for (int i = 0; i < 10; i++) begin
         at_pos();
         req_a = tbl[i].ra;
         req_b = tbl[i].rb;
         data_a = tbl[i].da;
         data_b = tbl[i].db;
         at_neg();
         chk($sformatf("table_row%0d", i), {gnt_a, gnt_b, busy, m_valid},
             {tbl[i].ega, tbl[i].egb, tbl[i].ebusy, tbl[i].emv});
      end
      chk("table_addr_offer", {m_data, m_first, m_last}, {ADDR_BYTE, 1'b1, 1'b0});
      at_pos();
      req_a = 1'b0;
      req_b = 1'b0;
      ready_en = 1'b1;
      wait_drain("table");
      foreach (log_q[i]) if (log_q[i].last) data_seq.push_back(log_q[i].data);
      chk("table_data_count", data_seq.size(), 5);
      for (int i = 0; i < 5 && i < data_seq.size(); i++)
         chk($sformatf("table_order%0d", i), data_seq[i], exp_seq[i]);
      model_check("table");

      // Single code: latency, byte framing, gap length.
      do_reset();
      ready_en = 1'b1;
      nack_mode = 0;
      at_pos();
      req_a = 1'b1;
      data_a = 8'h1C;
      at_neg();
      chk("single_gnt_a", gnt_a, 1);
      at_pos();
      req_a = 1'b0;
      at_neg();
      chk("single_valid_lat1", m_valid, 0);
      at_neg();
      chk("single_valid_lat2", {m_valid, m_data, m_first, m_last}, {1'b1, ADDR_BYTE, 1'b1, 1'b0});
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         at_neg();
         if (m_done && log_q.size() == 2) found = 1'b1;
      end
      chk("single_data_done_seen", found, 1);
      for (int i = 0; i < GAP; i++) begin
         at_neg();
         chk($sformatf("single_gap_busy%0d", i), busy, 1);
      end
      at_neg();
      chk("single_gap_end_busy", busy, 0);
      model_check("single");

      // NACK every address byte: four attempts, one drop, next code proceeds.
      do_reset();
      ready_en = 1'b1;
      nack_mode = 1;
      at_pos();
      req_a = 1'b1;
      data_a = 8'h55;
      at_pos();
      data_a = 8'h66;
      at_pos();
      req_a = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         at_neg();
         if (err) found = 1'b1;
      end
      chk("nack_err_seen", found, 1);
      chk("nack_attempts", log_q.size(), 4);
      chk("nack_drop_cnt_at_err", drop_cnt, 1);
      nack_mode = 0;
      wait_drain("nack");
      model_check("nack");

      // Zero code from B: granted, not queued.
      do_reset();
      at_pos();
      req_b = 1'b1;
      data_b = 8'h00;
      at_neg();
      chk("zero_gnt_b", {gnt_a, gnt_b}, 2'b01);
      at_pos();
      req_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk($sformatf("zero_busy%0d", i), {busy, m_valid}, 2'b00);
      end

      // Reset during DATA_WAIT with two codes still queued.
      do_reset();
      ready_en = 1'b1;
      nack_mode = 0;
      at_pos();
      req_a = 1'b1;
      data_a = 8'h31;
      at_pos();
      req_a = 1'b0;
      req_b = 1'b1;
      data_b = 8'h32;
      at_pos();
      req_b = 1'b0;
      req_a = 1'b1;
      data_a = 8'h33;
      at_pos();
      req_a = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         at_neg();
         if (log_q.size() == 2) found = 1'b1;
      end
      chk("rst_mid_data_accepted", found, 1);
      at_neg();
      chk("rst_mid_busy_before", busy, 1);
      rst = 1'b1;
      at_neg();
      chk("rst_mid_after", {m_valid, busy, err}, 3'b000);
      at_pos();
      rst = 1'b0;
      any_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         at_neg();
         if (m_valid || busy) any_valid = 1'b1;
      end
      chk("rst_mid_quiet", any_valid, 0);
      chk("rst_mid_no_tx", log_q.size(), 0);
      chk("rst_mid_no_err", {err_seen[7:0], drop_cnt}, 16'h0000);

      // Randomized traffic with random ready and random NACKs.
      do_reset();
      ready_rand = 1'b1;
      nack_mode = 2;
      last_b = 1'b1;
      n_grants = 0;
      for (int c = 0; c < 800; c++) begin
         at_pos();
         if (c < 700) begin
            req_a = 1'($urandom_range(0, 1));
            req_b = 1'($urandom_range(0, 1));
            data_a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            data_b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         end else begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         at_neg();
         if (gnt_a && gnt_b) chk("rand_one_grant", {gnt_a, gnt_b}, 2'b10);
         if ((gnt_a && !req_a) || (gnt_b && !req_b))
            chk("rand_grant_without_req", {req_a, req_b, gnt_a, gnt_b}, {req_a, req_b, 2'b00});
         if (req_a && req_b && (gnt_a || gnt_b))
            chk($sformatf("rand_rr_c%0d", c), gnt_a, last_b);
         if (gnt_a) begin
            last_b = 1'b0;
            n_grants++;
         end else if (gnt_b) begin
            last_b = 1'b1;
            n_grants++;
         end
      end
      chk("rand_some_grants", (n_grants > 20), 1);
      ready_rand = 1'b0;
      ready_en = 1'b1;
      wait_drain("random");
      model_check("random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
